// File: rtl/mips8_run_ctrl_if.sv
// Wishbone slave bundle between the management SoC and the MIPS8 run controller.
interface mips8_run_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/mips8_run_ctrl.sv
// Run controller for the MIPS8 user core: reset hold, bounded run, halt/step/resume,
// clock-enable gating, output pad arbitration and input pad synchronisation.
module mips8_run_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          CNT_W      = 16,
  parameter int          RST_CYCLES = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  mips8_run_ctrl_if.slave        wbs,
  output logic                   core_rst_o,
  output logic                   core_clk_en_o,
  input  logic [15:0]            core_io_out_i,
  input  logic [15:0]            core_io_oeb_i,
  output logic [7:0]             core_io_in_o,
  input  logic [7:0]             pad_io_in_i,
  output logic [15:0]            pad_io_out_o,
  output logic [15:0]            pad_io_oeb_o,
  output logic                   irq_o
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam int CMD_START  = 0;
  localparam int CMD_HALT   = 1;
  localparam int CMD_STEP   = 2;
  localparam int CMD_RESUME = 3;
  localparam int CMD_ABORT  = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RSTHOLD = 2'd1,
    S_RUN     = 2'd2,
    S_PAUSED  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   elapsed_q, elapsed_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               done_q, done_d;
  logic               step_q, step_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [4:0]         cmd_q, cmd_d;
  logic               pad_sel_q, pad_sel_d;
  logic               irq_en_q, irq_en_d;
  logic [31:0]        dbg_q, dbg_d;
  logic               irq_q, irq_d;
  logic [15:0]        pad_out_q, pad_out_d;
  logic [15:0]        pad_oeb_q, pad_oeb_d;
  logic [7:0]         sync1_q, sync2_q;

  logic               wb_req;
  logic [5:0]         word;
  logic               done_clr;
  logic               busy;
  logic               budget_hit;
  logic               core_rst;
  logic               clk_en;
  logic               unused_wb;

  // ack_q blocks a held strobe from being accepted twice in a row
  assign wb_req    = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q &
                     (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign word      = wbs.wbs_adr_i[7:2];
  assign unused_wb = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0]};
  assign busy      = (state_q == S_RUN) || (state_q == S_RSTHOLD);

  // >= rather than == so a resume past the budget still pauses after one cycle
  assign budget_hit = (state_q == S_RUN) && (cycles_q != '0) &&
                      (elapsed_q >= cycles_q - CNT_W'(1));

  always_comb begin
    ack_d     = wb_req;
    dat_d     = '0;
    cmd_d     = '0;
    pad_sel_d = pad_sel_q;
    irq_en_d  = irq_en_q;
    cycles_d  = cycles_q;
    dbg_d     = dbg_q;
    done_clr  = 1'b0;
    if (wb_req) begin
      if (wbs.wbs_we_i) begin
        case (word)
          6'h00: begin
            cmd_d[CMD_START]  = wbs.wbs_dat_i[0];
            cmd_d[CMD_HALT]   = wbs.wbs_dat_i[1];
            cmd_d[CMD_STEP]   = wbs.wbs_dat_i[2];
            cmd_d[CMD_RESUME] = wbs.wbs_dat_i[5];
            cmd_d[CMD_ABORT]  = wbs.wbs_dat_i[6];
            pad_sel_d         = wbs.wbs_dat_i[3];
            irq_en_d          = wbs.wbs_dat_i[4];
          end
          6'h01:   done_clr = wbs.wbs_dat_i[2];
          6'h02:   cycles_d = wbs.wbs_dat_i[CNT_W-1:0];
          6'h04:   dbg_d    = wbs.wbs_dat_i;
          default: ;
        endcase
      end else begin
        case (word)
          6'h00:   dat_d = {27'b0, irq_en_q, pad_sel_q, 3'b0};
          6'h01:   dat_d = {28'b0, busy, done_q, state_q};
          6'h02:   dat_d = 32'(cycles_q);
          6'h03:   dat_d = 32'(elapsed_q);
          6'h04:   dat_d = dbg_q;
          6'h05:   dat_d = {24'b0, sync2_q};
          default: dat_d = '0;
        endcase
      end
    end
  end

  // Next state: the highest-priority command bit alone decides; inapplicable ones are dropped
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    elapsed_d = clk_en ? elapsed_q + CNT_W'(1) : elapsed_q;
    done_d    = done_q & ~done_clr;
    step_d    = 1'b0;
    if (cmd_q[CMD_ABORT]) begin
      state_d = S_IDLE;
    end else if (cmd_q[CMD_START]) begin
      state_d   = S_RSTHOLD;
      hold_d    = HOLD_W'(RST_CYCLES - 1);
      elapsed_d = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_RSTHOLD: begin
          if (hold_q == '0) state_d = S_RUN;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        S_RUN: begin
          if (budget_hit) begin
            state_d = S_PAUSED;
            done_d  = 1'b1;
          end else if (cmd_q[CMD_HALT]) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (!cmd_q[CMD_HALT]) begin
            if (cmd_q[CMD_RESUME])    state_d = S_RUN;
            else if (cmd_q[CMD_STEP]) step_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    core_rst = 1'b1;
    clk_en   = 1'b0;
    case (state_q)
      S_RUN: begin
        core_rst = 1'b0;
        clk_en   = 1'b1;
      end
      S_PAUSED: begin
        core_rst = 1'b0;
        clk_en   = step_q;
      end
      default: ;
    endcase
  end

  // Core pads are only trusted once the core is out of reset
  always_comb begin
    irq_d = done_q & irq_en_q;
    if (pad_sel_q) begin
      pad_out_d = dbg_q[15:0];
      pad_oeb_d = dbg_q[31:16];
    end else if (state_q == S_RUN || state_q == S_PAUSED) begin
      pad_out_d = core_io_out_i;
      pad_oeb_d = core_io_oeb_i;
    end else begin
      pad_out_d = '0;
      pad_oeb_d = 16'hFFFF;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hold_q    <= '0;
      elapsed_q <= '0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      step_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      cmd_q     <= '0;
      pad_sel_q <= 1'b0;
      irq_en_q  <= 1'b0;
      dbg_q     <= '0;
      irq_q     <= 1'b0;
      pad_out_q <= '0;
      pad_oeb_q <= 16'hFFFF;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      hold_q    <= hold_d;
      elapsed_q <= elapsed_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      step_q    <= step_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      cmd_q     <= cmd_d;
      pad_sel_q <= pad_sel_d;
      irq_en_q  <= irq_en_d;
      dbg_q     <= dbg_d;
      irq_q     <= irq_d;
      pad_out_q <= pad_out_d;
      pad_oeb_q <= pad_oeb_d;
      sync1_q   <= pad_io_in_i;
      sync2_q   <= sync1_q;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign core_rst_o    = core_rst;
  assign core_clk_en_o = clk_en;
  assign core_io_in_o  = sync2_q;
  assign pad_io_out_o  = pad_out_q;
  assign pad_io_oeb_o  = pad_oeb_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_mips8_run_ctrl.sv
// Randomised bench for mips8_run_ctrl; expectations come from timing arithmetic on bus ack ticks.
module tb_mips8_run_ctrl;
  localparam int          R    = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0]  A_CTRL = 8'h00, A_STAT = 8'h04, A_CYC = 8'h08,
                          A_ELA = 8'h0C, A_DBG = 8'h10, A_PIN = 8'h14, A_BAD = 8'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rst, core_en, irq;
  logic [15:0] core_out, core_oeb, pad_out, pad_oeb;
  logic [7:0]  core_in, pad_in;

  always #5 clk = ~clk;

  mips8_run_ctrl_if wbs();

  mips8_run_ctrl #(.BASE_ADDR(BASE), .CNT_W(16), .RST_CYCLES(R)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs           (wbs),
    .core_rst_o    (core_rst),
    .core_clk_en_o (core_en),
    .core_io_out_i (core_out),
    .core_io_oeb_i (core_oeb),
    .core_io_in_o  (core_in),
    .pad_io_in_i   (pad_in),
    .pad_io_out_o  (pad_out),
    .pad_io_oeb_o  (pad_oeb),
    .irq_o         (irq)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  int   tick     = 0;
  int   en_cnt   = 0;
  int   dbl_ack  = 0;
  logic prev_ack = 1'b0;
  int   last_ack_tick = 0;

  always @(posedge clk) begin
    tick     <= tick + 1;
    prev_ack <= wbs.wbs_ack_o;
    if (core_en) en_cnt <= en_cnt + 1;
    if (wbs.wbs_ack_o && prev_ack) dbl_ack <= dbl_ack + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic acked);
    @(negedge clk);
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = wdat;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs.wbs_dat_o;
        last_ack_tick = tick;
      end
    end
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    @(negedge clk);
    if (acked) check("ack_single", {31'b0, wbs.wbs_ack_o}, 32'd0);
    $display("WB %s adr=%h dat=%h ack=%0d", we ? "W" : "R", adr, we ? wdat : rdat, acked);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] r;
    logic        a;
    wb_xfer(1'b1, BASE | 32'(off), d, r, a);
    check("wr_ack", {31'b0, a}, 32'd1);
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    logic        a;
    wb_xfer(1'b0, BASE | 32'(off), 32'd0, r, a);
    check({tag, "_ack"}, {31'b0, a}, 32'd1);
    check(tag, r, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at tick=%0d", tick);
    $fatal(1, "watchdog");
  end

  initial begin
    int          b, ie, n, s1, h1, m_el, base;
    logic [31:0] d, r;
    logic        a;
    logic [7:0]  v, old;

    rst = 1'b1;
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = 4'h0; wbs.wbs_adr_i = '0;   wbs.wbs_dat_i = '0;
    pad_in = 8'h00; core_out = 16'h0000; core_oeb = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_core_rst", {31'b0, core_rst}, 32'd1);
    check("rst_clk_en",   {31'b0, core_en}, 32'd0);
    check("rst_ack",      {31'b0, wbs.wbs_ack_o}, 32'd0);
    check("rst_dat",      wbs.wbs_dat_o, 32'd0);
    check("rst_pad_out",  {16'b0, pad_out}, 32'h0);
    check("rst_pad_oeb",  {16'b0, pad_oeb}, 32'hFFFF);
    check("rst_irq",      {31'b0, irq}, 32'd0);
    check("rst_core_in",  {24'b0, core_in}, 32'd0);
    wb_read(A_STAT, 32'd0, "rst_status");

    // Bounded runs: RST_CYCLES of reset, then exactly budget enabled cycles
    for (int it = 0; it < 3; it++) begin
      b  = $urandom_range(1, 40);
      ie = $urandom_range(0, 1);
      wb_write(A_CYC, 32'(b));
      wb_write(A_CTRL, 32'((ie << 4) | 1));
      n = 0;
      while (core_rst && n < 100) begin n++; @(negedge clk); end
      check("rst_hold_len", 32'(n), 32'(R));
      n = 0;
      while (core_en && n < 200) begin n++; @(negedge clk); end
      check("run_len", 32'(n), 32'(b));
      wb_read(A_STAT, 32'h7, "budget_status");
      wb_read(A_ELA, 32'(b), "budget_elapsed");
      check("irq_level", {31'b0, irq}, 32'(ie));
      wb_read(A_CTRL, 32'(ie << 4), "ctrl_readback");
      wb_write(A_STAT, 32'h4);
      @(negedge clk);
      wb_read(A_STAT, 32'h3, "done_w1c");
      check("irq_after_clr", {31'b0, irq}, 32'd0);
    end

    // Unbounded run, halt, steps, then resume past an already-exceeded budget
    wb_write(A_CYC, 32'd0);
    wb_write(A_CTRL, 32'h1);
    s1 = last_ack_tick;
    n  = $urandom_range(10, 30);
    repeat (n) @(negedge clk);
    wb_read(A_STAT, 32'hA, "run_status");
    wb_write(A_CTRL, 32'h2);
    h1   = last_ack_tick;
    m_el = h1 - s1 - R;
    wb_read(A_STAT, 32'h3, "halt_status");
    wb_read(A_ELA, 32'(m_el), "halt_elapsed");
    base = en_cnt;
    repeat (3) wb_write(A_CTRL, 32'h4);
    repeat (2) @(negedge clk);
    check("step_pulses", 32'(en_cnt - base), 32'd3);
    m_el += 3;
    wb_read(A_ELA, 32'(m_el), "step_elapsed");
    wb_read(A_STAT, 32'h3, "step_status");
    wb_write(A_CYC, 32'd2);
    base = en_cnt;
    wb_write(A_CTRL, 32'h20);
    repeat (3) @(negedge clk);
    check("resume_over_budget", 32'(en_cnt - base), 32'd1);
    m_el += 1;
    wb_read(A_STAT, 32'h7, "resume_status");
    wb_read(A_ELA, 32'(m_el), "resume_elapsed");

    // Command priority
    wb_write(A_CYC, 32'd0);
    wb_write(A_CTRL, 32'h1);
    repeat (8) @(negedge clk);
    wb_write(A_CTRL, 32'h43);
    wb_read(A_STAT, 32'h0, "abort_status");
    check("abort_core_rst", {31'b0, core_rst}, 32'd1);
    wb_write(A_CTRL, 32'h03);
    wb_read(A_STAT, 32'h9, "start_halt_status");
    wb_write(A_CTRL, 32'h40);

    // Debug pad override
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 32'h0000_A5A5 : $urandom;
      wb_write(A_DBG, d);
      wb_write(A_CTRL, 32'h8);
      check("dbg_pad_out", {16'b0, pad_out}, {16'b0, d[15:0]});
      check("dbg_pad_oeb", {16'b0, pad_oeb}, {16'b0, d[31:16]});
      wb_read(A_DBG, d, "dbg_readback");
    end
    core_out = 16'($urandom);
    core_oeb = 16'($urandom);
    wb_write(A_CTRL, 32'h0);
    check("idle_pad_out", {16'b0, pad_out}, 32'h0);
    check("idle_pad_oeb", {16'b0, pad_oeb}, 32'hFFFF);
    wb_write(A_CTRL, 32'h1);
    check("rsthold_pad_out", {16'b0, pad_out}, 32'h0);
    check("rsthold_pad_oeb", {16'b0, pad_oeb}, 32'hFFFF);
    repeat (R + 2) @(negedge clk);
    for (int it = 0; it < 3; it++) begin
      core_out = 16'($urandom);
      core_oeb = 16'($urandom);
      @(negedge clk);
      check("run_pad_out", {16'b0, pad_out}, {16'b0, core_out});
      check("run_pad_oeb", {16'b0, pad_oeb}, {16'b0, core_oeb});
    end
    wb_write(A_CTRL, 32'h40);

    // Input synchroniser latency
    for (int it = 0; it < 3; it++) begin
      old = pad_in;
      v   = (it == 0) ? 8'h3C : (pad_in ^ 8'($urandom_range(1, 255)));
      pad_in = v;
      @(negedge clk);
      check("sync_lat1", {24'b0, core_in}, {24'b0, old});
      @(negedge clk);
      check("sync_lat2", {24'b0, core_in}, {24'b0, v});
      wb_read(A_PIN, {24'b0, v}, "pad_in_reg");
    end

    // Unmapped offset and foreign base
    wb_write(A_BAD, 32'hDEAD_BEEF);
    wb_read(A_BAD, 32'h0, "unmapped_read");
    wb_read(A_CYC, 32'h0, "cycles_untouched");
    wb_xfer(1'b1, BASE + 32'h100, 32'h1, r, a);
    check("foreign_wr_noack", {31'b0, a}, 32'd0);
    wb_xfer(1'b0, 32'h3100_0004, 32'h0, r, a);
    check("foreign_rd_noack", {31'b0, a}, 32'd0);
    wb_read(A_STAT, 32'h0, "foreign_no_effect");

    @(negedge clk);
    check("double_ack", 32'(dbl_ack), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
